// File: rtl/hiscore_tracker.sv
// Session high-score keeper: digit-serial BCD compare at game over, commit, and record blink.
// Optional blink sequencing is compiled in with `define HISCORE_BLINK_EN.
module hiscore_tracker #(
    parameter int BLINK_TICKS  = 15,
    parameter int BLINK_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] i_score,
    input  logic        i_game_over_pulse,
    input  logic        i_game_start_pulse,
    input  logic        i_game_tick_60hz,
    output logic [15:0] o_hiscore,
    output logic        o_new_record,
    output logic        o_score_visible,
    output logic        o_busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        UPDATE  = 2'd2,
        BLINK   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] snap_q, snap_d;
    logic [15:0] hiscore_q, hiscore_d;
    logic [1:0]  digit_q, digit_d;
    logic        new_record_q, new_record_d;
    logic        visible_q, visible_d;
    logic        busy_q;
    logic [3:0]  snap_digit;
    logic [3:0]  hi_digit;

    assign snap_digit = snap_q[{digit_q, 2'b00} +: 4];
    assign hi_digit   = hiscore_q[{digit_q, 2'b00} +: 4];

`ifdef HISCORE_BLINK_EN
    localparam int TICK_W  = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam int PHASE_W = $clog2(2 * BLINK_CYCLES);

    logic [TICK_W-1:0]  tick_q, tick_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic               tick_last;
    logic               phase_last;

    assign tick_last  = (tick_q == TICK_W'(BLINK_TICKS - 1));
    assign phase_last = (phase_q == PHASE_W'(2 * BLINK_CYCLES - 1));
`else
    logic unused_blink;
    assign unused_blink = ^{i_game_tick_60hz, BLINK_TICKS[0], BLINK_CYCLES[0]};
`endif

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            snap_q       <= 16'h0000;
            hiscore_q    <= 16'h0000;
            digit_q      <= 2'd0;
            new_record_q <= 1'b0;
            visible_q    <= 1'b1;
            busy_q       <= 1'b0;
`ifdef HISCORE_BLINK_EN
            tick_q       <= '0;
            phase_q      <= '0;
`endif
        end else begin
            state_q      <= state_d;
            snap_q       <= snap_d;
            hiscore_q    <= hiscore_d;
            digit_q      <= digit_d;
            new_record_q <= new_record_d;
            visible_q    <= visible_d;
            busy_q       <= (state_d != IDLE);
`ifdef HISCORE_BLINK_EN
            tick_q       <= tick_d;
            phase_q      <= phase_d;
`endif
        end
    end

    // Next-state logic; snapshot and digit index follow the FSM walk
    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        digit_d = digit_q;
        case (state_q)
            IDLE: begin
                if (i_game_over_pulse) begin
                    snap_d  = i_score;
                    digit_d = 2'd3;
                    state_d = COMPARE;
                end
            end
            COMPARE: begin
                if (snap_digit > hi_digit) begin
                    state_d = UPDATE;
                end else if (snap_digit < hi_digit) begin
                    state_d = IDLE;
                end else if (digit_q == 2'd0) begin
                    state_d = IDLE;
                end else begin
                    digit_d = digit_q - 2'd1;
                end
            end
            UPDATE: begin
`ifdef HISCORE_BLINK_EN
                state_d = BLINK;
`else
                state_d = IDLE;
`endif
            end
            BLINK: begin
`ifdef HISCORE_BLINK_EN
                if (i_game_start_pulse) begin
                    state_d = IDLE;
                end else if (i_game_tick_60hz && tick_last && phase_last) begin
                    state_d = IDLE;
                end
`else
                state_d = IDLE;
`endif
            end
        endcase
    end

    // Output / counter next values
    always_comb begin
        hiscore_d    = hiscore_q;
        new_record_d = new_record_q;
        visible_d    = visible_q;
`ifdef HISCORE_BLINK_EN
        tick_d       = tick_q;
        phase_d      = phase_q;
`endif
        case (state_q)
            IDLE: begin
                if (i_game_start_pulse) begin
                    new_record_d = 1'b0;
                end
            end
            COMPARE: begin
            end
            UPDATE: begin
                hiscore_d    = snap_q;
                new_record_d = 1'b1;
`ifdef HISCORE_BLINK_EN
                tick_d       = '0;
                phase_d      = '0;
                visible_d    = 1'b0;
`endif
            end
            BLINK: begin
`ifdef HISCORE_BLINK_EN
                if (i_game_start_pulse) begin
                    visible_d    = 1'b1;
                    new_record_d = 1'b0;
                    tick_d       = '0;
                    phase_d      = '0;
                end else if (i_game_tick_60hz) begin
                    if (tick_last) begin
                        tick_d = '0;
                        // Leaving after the last on-phase: force visible rather than toggle
                        if (phase_last) begin
                            phase_d   = '0;
                            visible_d = 1'b1;
                        end else begin
                            phase_d   = phase_q + 1'b1;
                            visible_d = ~visible_q;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
`endif
            end
        endcase
    end

    assign o_hiscore       = hiscore_q;
    assign o_new_record    = new_record_q;
    assign o_score_visible = visible_q;
    assign o_busy          = busy_q;

endmodule

// File: tb/tb_hiscore_tracker.sv
// Self-checking bench for hiscore_tracker; high-score rules modelled with plain numeric compare.
// Builds with or without HISCORE_BLINK_EN.
module tb_hiscore_tracker;

    localparam int BT = 2;
    localparam int BC = 2;
`ifdef HISCORE_BLINK_EN
    localparam int BLINK_EN = 1;
`else
    localparam int BLINK_EN = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] i_score = 16'h0000;
    logic        i_game_over_pulse = 1'b0;
    logic        i_game_start_pulse = 1'b0;
    logic        i_game_tick_60hz = 1'b0;
    logic [15:0] o_hiscore;
    logic        o_new_record;
    logic        o_score_visible;
    logic        o_busy;

    int checks = 0;
    int errors = 0;
    int hi_m = 0;
    bit nr_m = 1'b0;

    hiscore_tracker #(.BLINK_TICKS(BT), .BLINK_CYCLES(BC)) dut (
        .clk(clk),
        .rst(rst),
        .i_score(i_score),
        .i_game_over_pulse(i_game_over_pulse),
        .i_game_start_pulse(i_game_start_pulse),
        .i_game_tick_60hz(i_game_tick_60hz),
        .o_hiscore(o_hiscore),
        .o_new_record(o_new_record),
        .o_score_visible(o_score_visible),
        .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    // Number of leading (most significant) digits that are equal
    function automatic int lead_eq(input int a, input int b);
        int n = 0;
        for (int i = 3; i >= 0; i--) begin
            if (((a >> (4 * i)) & 15) == ((b >> (4 * i)) & 15)) n++;
            else break;
        end
        return n;
    endfunction

    function automatic int exp_upd(input int sc, input int hi);
        return (sc > hi) ? lead_eq(sc, hi) + 2 : 0;
    endfunction

    function automatic int exp_busy(input int sc, input int hi);
        if (sc > hi) return lead_eq(sc, hi) + 2 + BLINK_EN;
        if (sc == hi) return 4;
        return lead_eq(sc, hi) + 1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_pulse();
        i_game_start_pulse = 1'b1;
        step();
        i_game_start_pulse = 1'b0;
    endtask

    // Pulse game over and measure the edge of the high-score change and busy length
    task automatic play(input logic [15:0] sc, output int upd_edge, output int busy_cnt,
                        output bit timeout);
        logic [15:0] h0;
        h0 = o_hiscore;
        upd_edge = 0;
        busy_cnt = 0;
        timeout = 1'b1;
        i_score = sc;
        i_game_over_pulse = 1'b1;
        step();
        i_game_over_pulse = 1'b0;
        for (int k = 0; k <= 12; k++) begin
            if (k > 0) step();
            if (upd_edge == 0 && o_hiscore !== h0) upd_edge = k;
            if (o_busy !== 1'b1) begin
                timeout = 1'b0;
                break;
            end
            busy_cnt++;
            if (BLINK_EN == 1 && upd_edge != 0) begin
                timeout = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        checks++;
        if ({o_hiscore, o_new_record, o_score_visible, o_busy} !== {16'h0000, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_values got hi=%h nr=%b vis=%b busy=%b want 0000 0 1 0",
                     o_hiscore, o_new_record, o_score_visible, o_busy);
        end
        hi_m = 0;
        nr_m = 1'b0;
    endtask

    task automatic test_first_record();
        int u, b;
        bit to;
        play(16'h0042, u, b, to);
        checks++;
        if (to || u != 4 || b != exp_busy(16'h0042, 0)) begin
            errors++;
            $display("FAIL first_record_timing got upd=%0d busy=%0d to=%0b want upd=4 busy=%0d",
                     u, b, to, exp_busy(16'h0042, 0));
        end
        checks++;
        if (o_hiscore !== 16'h0042 || o_new_record !== 1'b1) begin
            errors++;
            $display("FAIL first_record_value got hi=%h nr=%b want 0042 1", o_hiscore, o_new_record);
        end
        hi_m = 16'h0042;
        start_pulse();
        checks++;
        if (o_new_record !== 1'b0 || o_busy !== 1'b0 || o_score_visible !== 1'b1) begin
            errors++;
            $display("FAIL start_clears got nr=%b busy=%b vis=%b want 0 0 1",
                     o_new_record, o_busy, o_score_visible);
        end
    endtask

    task automatic test_tie();
        int u, b;
        bit to;
        play(16'h0042, u, b, to);
        checks++;
        if (to || u != 0 || b != 4) begin
            errors++;
            $display("FAIL tie_timing got upd=%0d busy=%0d to=%0b want upd=0 busy=4", u, b, to);
        end
        checks++;
        if (o_hiscore !== 16'h0042 || o_new_record !== 1'b0) begin
            errors++;
            $display("FAIL tie_value got hi=%h nr=%b want 0042 0", o_hiscore, o_new_record);
        end
    endtask

    task automatic test_blink();
        int u, b, n, ph;
        bit to, ev, eb;
        play(16'h0900, u, b, to);
        checks++;
        if (to || u != exp_upd(16'h0900, hi_m) || o_hiscore !== 16'h0900) begin
            errors++;
            $display("FAIL record_0900 got upd=%0d hi=%h to=%0b want upd=%0d hi=0900",
                     u, o_hiscore, to, exp_upd(16'h0900, hi_m));
        end
        hi_m = 16'h0900;
        checks++;
        if (o_score_visible !== (BLINK_EN == 1 ? 1'b0 : 1'b1)) begin
            errors++;
            $display("FAIL blink_start_vis got %b want %0d", o_score_visible, 1 - BLINK_EN);
        end
        n = 0;
        for (int c = 1; c <= 3 * (2 * BC * BT + 2); c++) begin
            i_game_tick_60hz = (c % 3 == 0);
            step();
            if (i_game_tick_60hz) begin
                i_game_tick_60hz = 1'b0;
                n++;
                ph = n / BT;
                if (BLINK_EN == 0 || ph >= 2 * BC) begin
                    ev = 1'b1;
                    eb = 1'b0;
                end else begin
                    ev = ph[0];
                    eb = 1'b1;
                end
                checks++;
                if (o_score_visible !== ev || o_busy !== eb) begin
                    errors++;
                    $display("FAIL blink_tick%0d got vis=%b busy=%b want vis=%b busy=%b",
                             n, o_score_visible, o_busy, ev, eb);
                end
            end
        end
        checks++;
        if (o_new_record !== 1'b1) begin
            errors++;
            $display("FAIL blink_keeps_record got nr=%b want 1", o_new_record);
        end
        start_pulse();
    endtask

    task automatic test_less();
        int u, b;
        bit to;
        play(16'h0899, u, b, to);
        checks++;
        if (to || u != 0 || b != 2) begin
            errors++;
            $display("FAIL less_timing got upd=%0d busy=%0d to=%0b want upd=0 busy=2", u, b, to);
        end
        checks++;
        if (o_hiscore !== 16'h0900 || o_new_record !== 1'b0) begin
            errors++;
            $display("FAIL less_value got hi=%h nr=%b want 0900 0", o_hiscore, o_new_record);
        end
    endtask

    task automatic test_start_abort();
        int u, b;
        bit to;
        play(16'h1000, u, b, to);
        hi_m = 16'h1000;
        checks++;
        if (to || u != 2 || o_hiscore !== 16'h1000) begin
            errors++;
            $display("FAIL record_1000 got upd=%0d hi=%h want upd=2 hi=1000", u, o_hiscore);
        end
        i_game_tick_60hz = 1'b1;
        step();
        i_game_tick_60hz = 1'b1;
        i_game_start_pulse = 1'b1;
        step();
        i_game_tick_60hz = 1'b0;
        i_game_start_pulse = 1'b0;
        checks++;
        if (o_score_visible !== 1'b1 || o_new_record !== 1'b0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL start_abort got vis=%b nr=%b busy=%b want 1 0 0",
                     o_score_visible, o_new_record, o_busy);
        end
        for (int t = 0; t < 3 * BT; t++) begin
            i_game_tick_60hz = 1'b1;
            step();
            i_game_tick_60hz = 1'b0;
            step();
        end
        checks++;
        if (o_score_visible !== 1'b1 || o_busy !== 1'b0 || o_hiscore !== 16'h1000) begin
            errors++;
            $display("FAIL after_abort got vis=%b busy=%b hi=%h want 1 0 1000",
                     o_score_visible, o_busy, o_hiscore);
        end
    endtask

    task automatic test_ignored_over();
        int u;
        logic [15:0] h0;
        h0 = o_hiscore;
        u = 0;
        i_score = 16'h1005;
        i_game_over_pulse = 1'b1;
        step();
        i_score = 16'h9999;
        i_game_start_pulse = 1'b1;
        step();
        i_game_over_pulse = 1'b0;
        i_game_start_pulse = 1'b0;
        if (o_hiscore !== h0) u = 1;
        for (int k = 2; k <= 10; k++) begin
            step();
            if (u == 0 && o_hiscore !== h0) u = k;
        end
        checks++;
        if (u != exp_upd(16'h1005, hi_m) || o_hiscore !== 16'h1005 || o_new_record !== 1'b1) begin
            errors++;
            $display("FAIL ignored_over got upd=%0d hi=%h nr=%b want upd=%0d hi=1005 nr=1",
                     u, o_hiscore, o_new_record, exp_upd(16'h1005, hi_m));
        end
        hi_m = 16'h1005;
        start_pulse();
    endtask

    task automatic test_reset_mid();
        int u, b;
        bit to;
        if (BLINK_EN == 1) begin
            play(16'h1100, u, b, to);
            i_game_tick_60hz = 1'b1;
            step();
            i_game_tick_60hz = 1'b0;
        end else begin
            i_score = 16'h1100;
            i_game_over_pulse = 1'b1;
            step();
            i_game_over_pulse = 1'b0;
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({o_hiscore, o_new_record, o_score_visible, o_busy} !== {16'h0000, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid got hi=%h nr=%b vis=%b busy=%b want 0000 0 1 0",
                     o_hiscore, o_new_record, o_score_visible, o_busy);
        end
        hi_m = 0;
        nr_m = 1'b0;
    endtask

    task automatic test_random();
        int u, b, sel, j;
        bit to;
        logic [15:0] sc;
        for (int it = 0; it < 40; it++) begin
            if (it % 10 == 9) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
                hi_m = 0;
            end
            sel = $urandom_range(0, 2);
            if (sel == 0) begin
                sc = hi_m[15:0];
            end else if (sel == 1) begin
                sc = 16'($urandom);
            end else begin
                j = $urandom_range(0, 3);
                sc = hi_m[15:0];
                sc[4*j +: 4] = 4'($urandom);
            end
            play(sc, u, b, to);
            checks++;
            if (to || u != exp_upd(sc, hi_m) || b != exp_busy(sc, hi_m)) begin
                errors++;
                $display("FAIL rand%0d_timing sc=%h hi=%h got upd=%0d busy=%0d want upd=%0d busy=%0d",
                         it, sc, hi_m[15:0], u, b, exp_upd(sc, hi_m), exp_busy(sc, hi_m));
            end
            nr_m = (sc > hi_m[15:0]);
            if (sc > hi_m[15:0]) hi_m = sc;
            checks++;
            if (o_hiscore !== hi_m[15:0] || o_new_record !== nr_m) begin
                errors++;
                $display("FAIL rand%0d_value got hi=%h nr=%b want hi=%h nr=%b",
                         it, o_hiscore, o_new_record, hi_m[15:0], nr_m);
            end
            start_pulse();
            nr_m = 1'b0;
            checks++;
            if (o_busy !== 1'b0 || o_score_visible !== 1'b1 || o_new_record !== nr_m) begin
                errors++;
                $display("FAIL rand%0d_idle got busy=%b vis=%b nr=%b want 0 1 0",
                         it, o_busy, o_score_visible, o_new_record);
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_record();
        test_tie();
        test_blink();
        test_less();
        test_start_abort();
        test_ignored_over();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
